// File: rtl/alu_pkg.sv
// Shared types for the multicycle ALU: operation codes, branch opcodes, FSM states.
// Mul/div support is compiled in only when MULTICYCLE_ALU_MULDIV_EN is defined.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_PZ    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_NOR   = 4'b0101,
    ALU_SUB   = 4'b0110,
    ALU_SLTU  = 4'b0111,
    ALU_MULT  = 4'b1000,
    ALU_MULTU = 4'b1001,
    ALU_DIV   = 4'b1010,
    ALU_DIVU  = 4'b1011,
    ALU_SLT   = 4'b1111
  } alu_op_e;

  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BLEZ = 6'b000110;
  localparam logic [5:0] OP_BGTZ = 6'b000111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } alu_state_e;

  function automatic logic is_muldiv(input logic [3:0] c);
    return c[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider core.
// hi_o/lo_o show the values after the current step so the caller can latch on the last one.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             last_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   t;

  // One iteration: add-and-shift-right for mul, shift-left-and-subtract for div.
  always_comb begin
    acc_d = acc_q;
    lo_d  = lo_q;
    sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    t     = {acc_q, lo_q[WIDTH-1]};
    if (div_i) begin
      if (t >= {1'b0, b_q}) begin
        acc_d = WIDTH'(t - {1'b0, b_q});
        lo_d  = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = t[WIDTH-1:0];
        lo_d  = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d = sum[WIDTH:1];
      lo_d  = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Operand latch on load, then one bit per step with a down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      acc_q <= '0;
      lo_q  <= a_i;
      b_q   <= b_i;
      cnt_q <= CW'(WIDTH - 1);
    end else if (step_i) begin
      acc_q <= acc_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign hi_o   = acc_d;
  assign lo_o   = lo_d;
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/multicycle_alu.sv
// Registered ALU with ready/start/valid_out handshake and branch-condition flag.
// Define MULTICYCLE_ALU_MULDIV_EN to build the iterative MULT/MULTU/DIV/DIVU path.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             ready,
  output logic             valid_out,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] hi_result,
  output logic             zero
);

  alu_state_e       state_q;
  logic             ready_q;
  logic             valid_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] hi_q;
  logic             zero_q;
  logic [WIDTH-1:0] res1_d;
  logic [WIDTH-1:0] hi1_d;

  function automatic logic br_zero(
    input logic [5:0]       opc,
    input logic             pz,
    input logic [WIDTH-1:0] res,
    input logic [WIDTH-1:0] a
  );
    if (opc == OP_BEQ)       return res == '0;
    else if (opc == OP_BNE)  return res != '0;
    else if (opc == OP_BLEZ) return a[WIDTH-1] || (a == '0);
    else if (opc == OP_BGTZ) return !a[WIDTH-1] && (a != '0);
    else                     return pz;
  endfunction

`ifdef MULTICYCLE_ALU_MULDIV_EN
  logic                 dz;
  logic                 sgn;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 md_load;
  logic                 md_step;
  logic [WIDTH-1:0]     md_hi;
  logic [WIDTH-1:0]     md_lo;
  logic                 md_last;
  logic [5:0]           opc_q;
  logic [WIDTH-1:0]     a_q;
  logic                 div_q;
  logic                 negq_q;
  logic                 negr_q;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     md_res;
  logic [WIDTH-1:0]     md_rem;

  assign dz      = (alu_control[3:1] == 3'b101) && (src_b == '0);
  assign sgn     = !alu_control[0];
  assign a_mag   = (sgn && src_a[WIDTH-1]) ? -src_a : src_a;
  assign b_mag   = (sgn && src_b[WIDTH-1]) ? -src_b : src_b;
  assign md_load = (state_q == IDLE) && start && is_muldiv(alu_control) && !dz;
  assign md_step = (state_q == MUL) || (state_q == DIV);

  muldiv_iter #(.WIDTH(WIDTH)) u_md (
    .clk    (clk),
    .reset  (reset),
    .load_i (md_load),
    .step_i (md_step),
    .div_i  (state_q == DIV),
    .a_i    (a_mag),
    .b_i    (b_mag),
    .hi_o   (md_hi),
    .lo_o   (md_lo),
    .last_o (md_last)
  );

  // Restore signs on the magnitude result of the final iteration.
  always_comb begin
    prod   = {md_hi, md_lo};
    md_res = md_lo;
    md_rem = md_hi;
    if (div_q) begin
      md_res = negq_q ? -md_lo : md_lo;
      md_rem = negr_q ? -md_hi : md_hi;
    end else begin
      if (negq_q) prod = -prod;
      md_res = prod[WIDTH-1:0];
      md_rem = prod[2*WIDTH-1:WIDTH];
    end
  end
`endif

  // Single-cycle results; divide by zero also resolves here.
  always_comb begin
    res1_d = '0;
    hi1_d  = '0;
    case (alu_control)
      ALU_AND:  res1_d = src_a & src_b;
      ALU_OR:   res1_d = src_a | src_b;
      ALU_ADD:  res1_d = src_a + src_b;
      ALU_XOR:  res1_d = src_a ^ src_b;
      ALU_NOR:  res1_d = ~(src_a | src_b);
      ALU_SUB:  res1_d = src_a - src_b;
      ALU_SLTU: res1_d = {{(WIDTH-1){1'b0}}, src_a < src_b};
      ALU_SLT:  res1_d = {{(WIDTH-1){1'b0}},
                          $signed(src_a) < $signed(src_b)};
      default:  res1_d = '0;
    endcase
`ifdef MULTICYCLE_ALU_MULDIV_EN
    if (dz) begin
      res1_d = '1;
      hi1_d  = src_a;
    end
`endif
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
`ifdef MULTICYCLE_ALU_MULDIV_EN
      opc_q   <= '0;
      a_q     <= '0;
      div_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            ready_q <= 1'b0;
`ifdef MULTICYCLE_ALU_MULDIV_EN
            opc_q  <= opcode;
            a_q    <= src_a;
            div_q  <= alu_control[1];
            negq_q <= sgn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            negr_q <= sgn & src_a[WIDTH-1];
            if (md_load) begin
              state_q <= alu_control[1] ? DIV : MUL;
            end else
`endif
            begin
              res_q   <= res1_d;
              hi_q    <= hi1_d;
              zero_q  <= br_zero(opcode, alu_control == ALU_PZ,
                                 res1_d, src_a);
              valid_q <= 1'b1;
              state_q <= DONE;
            end
          end
        end
`ifdef MULTICYCLE_ALU_MULDIV_EN
        MUL, DIV: begin
          if (md_last) begin
            res_q   <= md_res;
            hi_q    <= md_rem;
            zero_q  <= br_zero(opc_q, 1'b0, md_res, a_q);
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
`endif
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready      = ready_q;
  assign valid_out  = valid_q;
  assign alu_result = res_q;
  assign hi_result  = hi_q;
  assign zero       = zero_q;

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised, registered successor to the datapath's single-cycle ALU. It executes logic, arithmetic and compare operations in one cycle. Optional iterative multiply/divide operations take WIDTH+1 cycles. A ready/start/valid_out handshake lets the multicycle controller stall while the unit is busy. It also produces the generalised branch-condition flag (beq, bne, blez, bgtz, jump) consumed by PC-select logic.

## Interface
- WIDTH, 32: operand/result width; must be ≥ 4 and even.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  launches an operation when ready=1; ignored otherwise.
- opcode  in  6  instruction opcode, sampled with start; selects the branch condition.
- alu_control  in  4  operation select, sampled with start.
- src_a  in  WIDTH  first operand, sampled with start.
- src_b  in  WIDTH  second operand, sampled with start.
- ready  out  1  unit idle and able to accept start.
- valid_out  out  1  one-cycle pulse: alu_result, hi_result and zero are new.
- alu_result  out  WIDTH  result; product low half or quotient for mul/div.
- hi_result  out  WIDTH  product high half or remainder; 0 for other ops.
- zero  out  1  branch/jump-taken flag.

## Operation
- alu_control encoding:
  - 0000 AND; 0001 OR; 0010 ADD (wraps mod 2^WIDTH); 0011 PASS-ZERO (result 0, zero forced 1).
  - 0100 XOR; 0101 NOR; 0110 SUB (wraps); 0111 SLTU (unsigned); 1111 SLT (signed); result is 1 or 0.
  - 1000 MULT (signed); 1001 MULTU; 1010 DIV (signed); 1011 DIVU.
  - 1100–1110 reserved: result 0, latency 1.
- zero rule, in priority order, computed on the final result or the latched operands:
  - opcode 000100 (beq): result == 0.
  - opcode 000101 (bne): result != 0.
  - opcode 000110 (blez): signed src_a ≤ 0.
  - opcode 000111 (bgtz): signed src_a > 0.
  - alu_control 0011: 1.
  - Otherwise 0.
- FSM states:
  - IDLE: ready=1. start with a 1-cycle op → DONE. start with a mul/div op → latch operands, iteration counter = WIDTH-1, → MUL or DIV.
  - MUL: radix-2 shift-add on operand magnitudes, one bit per cycle. When the counter reaches 0 → DONE.
  - DIV: restoring divide, one quotient bit per cycle. When the counter reaches 0 → DONE.
  - DONE: drive the registered results and assert valid_out for one cycle → IDLE.
- Signed mul/div: operate on magnitudes, then fix signs in DONE. Quotient sign = sign(a)^sign(b). Remainder takes the sign of the dividend.
- Divide by zero: skips DIV and goes IDLE → DONE. Quotient = all ones, remainder = src_a.
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0. Computed by the normal path, no special state.
- Outputs hold their last values until the next valid_out.

## Timing
- Reset values: ready=1, valid_out=0, alu_result=0, hi_result=0, zero=0, FSM=IDLE.
- Reset asserted mid-operation aborts immediately. No valid_out is produced for the aborted op.
- 1-cycle ops: start in cycle N → valid_out in cycle N+1. ready=0 only during N+1, so back-to-back issue is possible every 2 cycles.
- Mul/div: start in N → valid_out in N+WIDTH+1. ready stays low from N+1 until valid_out, inclusive.
- Divide by zero: valid_out in N+1.
- start while ready=0 is ignored; input changes while busy have no effect.
- ready is registered; no combinational path from start to ready.

## Configuration
- MULTICYCLE_ALU_MULDIV_EN defined: MUL/DIV states, datapath and the 1000–1011 encodings are implemented as above.
- Not defined: MUL/DIV logic is removed. Codes 1000–1011 behave as reserved (result 0, hi_result 0, latency 1), and the FSM has only IDLE and DONE.

## Structure
- Package alu_pkg holds:
  - alu_op_e enum (4-bit encodings above);
  - branch opcode localparams OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ;
  - alu_state_e enum (IDLE, MUL, DIV, DONE).
- One sub-module, muldiv_iter: the shared shift register, accumulator and counter for MUL/DIV, instantiated only under MULTICYCLE_ALU_MULDIV_EN. Top level keeps the FSM, 1-cycle ops and branch logic.

## Test plan
- Reset, then ADD 0xFFFFFFFF+1 with opcode 000100 → valid_out at N+1, alu_result=0, zero=1.
- SUB 5-7 with opcode 000101 → result 0xFFFFFFFE, zero=1. SLT 0xFFFFFFFF,1 → 1. SLTU with the same operands → 0.
- blez with src_a=0 → zero=1. bgtz with src_a=0x80000000 → zero=0. alu_control 0011 → zero=1, result 0.
- MULT 0xFFFFFFFD × 7 → valid_out at N+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB. start pulsed during busy is ignored.
- DIV -7/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIVU 9/0 → valid_out at N+1, quotient 0xFFFFFFFF, remainder 9. DIV 0x80000000/-1 → quotient 0x80000000, remainder 0.
- Reset mid-MULT at cycle N+10 → outputs 0 and ready=1 immediately, no valid_out. Rebuild without the macro: MULTU → result 0 at N+1.
